// File: rtl/tx_xgmii_framer.sv
// Frames packet-FIFO words onto XGMII: start/preamble, data, terminate, IFG idles.
// Define TX_FRAMER_CUT_THROUGH_EN for cut-through start with underrun drop/count.
module tx_xgmii_framer #(
    parameter int unsigned IFG_WORDS = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      fifo_dout,
    input  logic             fifo_eop,
    input  logic [2:0]       fifo_bcnt,
    input  logic             fifo_empty,
    input  logic             pkt_avail,
    output logic             fifo_rd,
    output logic [63:0]      xgmii_txd,
    output logic [7:0]       xgmii_txc,
    output logic             tx_busy,
    output logic [CNT_W-1:0] underrun_cnt
);
    localparam logic [63:0] IDLE_W = {8{8'h07}};
    localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_W = {{7{8'h07}}, 8'hFD};
    localparam logic [63:0] ERR_W  = {8{8'hFE}};
    localparam logic [2:0]  IFG_N  = 3'(IFG_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_TERM,
        S_IFG
`ifdef TX_FRAMER_CUT_THROUGH_EN
        , S_DROP
`endif
    } state_t;

    // With no gap words the terminate leads straight back to IDLE.
    localparam state_t AFTER_T = (IFG_WORDS == 0) ? S_IDLE : S_IFG;

    state_t      state_q;
    logic [63:0] txd_q;
    logic [7:0]  txc_q;
    logic [2:0]  ifg_q;
    logic        start;
    logic [63:0] tail_txd;
    logic [7:0]  tail_txc;

`ifdef TX_FRAMER_CUT_THROUGH_EN
    logic             unused_pa;
    logic [CNT_W-1:0] cnt_q;
    assign unused_pa = pkt_avail;
    assign start     = !fifo_empty;
    assign fifo_rd   = !rst && !fifo_empty
                     && (state_q == S_DATA || state_q == S_DROP);
`else
    assign start   = !fifo_empty && pkt_avail;
    assign fifo_rd = !rst && !fifo_empty && (state_q == S_DATA);
`endif

    assign xgmii_txd = txd_q;
    assign xgmii_txc = txc_q;
    assign tx_busy   = (state_q != S_IDLE);

    always_comb begin
        tail_txd = IDLE_W;
        tail_txc = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) < fifo_bcnt) begin
                tail_txd[i*8 +: 8] = fifo_dout[i*8 +: 8];
                tail_txc[i]        = 1'b0;
            end else if (3'(i) == fifo_bcnt) begin
                tail_txd[i*8 +: 8] = 8'hFD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            txd_q   <= IDLE_W;
            txc_q   <= 8'hFF;
            ifg_q   <= 3'd0;
        end else begin
            txd_q <= IDLE_W;
            txc_q <= 8'hFF;
            unique case (state_q)
                S_IDLE: if (start) state_q <= S_PRE;
                S_PRE: begin
                    txd_q   <= PRE_W;
                    txc_q   <= 8'h01;
                    state_q <= S_DATA;
                end
                S_DATA: begin
                    if (!fifo_empty) begin
                        txd_q <= fifo_dout;
                        txc_q <= 8'h00;
                        if (fifo_eop && fifo_bcnt == 3'd0) begin
                            state_q <= S_TERM;
                        end else if (fifo_eop) begin
                            txd_q   <= tail_txd;
                            txc_q   <= tail_txc;
                            state_q <= AFTER_T;
                            ifg_q   <= IFG_N;
                        end
                    end else begin
                        txd_q <= ERR_W;
`ifdef TX_FRAMER_CUT_THROUGH_EN
                        state_q <= S_DROP;
`else
                        state_q <= AFTER_T;
                        ifg_q   <= IFG_N;
`endif
                    end
                end
                S_TERM: begin
                    txd_q   <= TERM_W;
                    state_q <= AFTER_T;
                    ifg_q   <= IFG_N;
                end
                S_IFG: begin
                    if (ifg_q <= 3'd1) state_q <= S_IDLE;
                    else ifg_q <= ifg_q - 3'd1;
                end
`ifdef TX_FRAMER_CUT_THROUGH_EN
                S_DROP: begin
                    if (!fifo_empty && fifo_eop) begin
                        state_q <= AFTER_T;
                        ifg_q   <= IFG_N;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef TX_FRAMER_CUT_THROUGH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == S_DATA && fifo_empty && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
    assign underrun_cnt = cnt_q;
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_tx_xgmii_framer.sv
// Bench for tx_xgmii_framer: FIFO model plus expected XGMII stream built per packet.
module tb_tx_xgmii_framer;
    localparam int IFG = 1;
    localparam logic [71:0] IDLE_X = {8'hFF, {8{8'h07}}};
    localparam logic [71:0] PRE_X  = {8'h01, 64'hD5555555555555FB};
    localparam logic [71:0] TERM_X = {8'hFF, {7{8'h07}}, 8'hFD};
    localparam logic [71:0] ERR_X  = {8'hFF, {8{8'hFE}}};

    typedef struct packed {
        logic [63:0] d;
        logic        eop;
        logic [2:0]  bcnt;
    } fw_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] fifo_dout;
    logic        fifo_eop;
    logic [2:0]  fifo_bcnt;
    logic        fifo_empty;
    logic        pkt_avail;
    logic        fifo_rd;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        tx_busy;
    logic [15:0] underrun_cnt;

    fw_t         fq[$];
    logic [71:0] exq[$];
    logic        pa_hold;
    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;

    always #5 clk = ~clk;

    tx_xgmii_framer #(.IFG_WORDS(IFG), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .fifo_dout(fifo_dout), .fifo_eop(fifo_eop),
        .fifo_bcnt(fifo_bcnt), .fifo_empty(fifo_empty),
        .pkt_avail(pkt_avail), .fifo_rd(fifo_rd),
        .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc),
        .tx_busy(tx_busy), .underrun_cnt(underrun_cnt)
    );

    task automatic chk(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] tail(input logic [63:0] d, input int n);
        logic [71:0] r;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                r[i*8 +: 8] = d[i*8 +: 8];
                r[64+i]     = 1'b0;
            end else begin
                r[i*8 +: 8] = (i == n) ? 8'hFD : 8'h07;
                r[64+i]     = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic drive_head();
        logic any_eop;
        any_eop = 1'b0;
        foreach (fq[i]) if (fq[i].eop) any_eop = 1'b1;
        if (fq.size() > 0) begin
            fifo_dout  = fq[0].d;
            fifo_eop   = fq[0].eop;
            fifo_bcnt  = fq[0].bcnt;
            fifo_empty = 1'b0;
        end else begin
            fifo_dout  = '0;
            fifo_eop   = 1'b0;
            fifo_bcnt  = 3'd0;
            fifo_empty = 1'b1;
        end
        pkt_avail = any_eop && !pa_hold;
    endtask

    task automatic step();
        logic popped;
        @(negedge clk);
        popped = fifo_rd;
        chk("rd_while_empty", 72'(fifo_rd & fifo_empty), 72'd0);
        @(posedge clk);
        #1;
        if (popped && fq.size() > 0) begin
            void'(fq.pop_front());
            pops++;
        end
        drive_head();
    endtask

    // Expected per packet: IDLE-state idle, preamble, data, terminate, gap idles.
    task automatic add_pkt(input int len, input logic [2:0] bc,
                           input logic [63:0] fixed_d, input bit use_fixed);
        fw_t w;
        exq.push_back(IDLE_X);
        exq.push_back(PRE_X);
        for (int i = 0; i < len; i++) begin
            w.d    = use_fixed ? fixed_d + 64'(i)
                               : {$urandom, $urandom};
            w.eop  = (i == len - 1);
            w.bcnt = w.eop ? bc : 3'd0;
            fq.push_back(w);
            if (!w.eop || bc == 3'd0) exq.push_back({8'h00, w.d});
            else exq.push_back(tail(w.d, int'(bc)));
        end
        if (bc == 3'd0) exq.push_back(TERM_X);
        for (int i = 0; i < IFG; i++) exq.push_back(IDLE_X);
    endtask

    task automatic run_stream(input string tag, input int nwords);
        int p0;
        int n;
        p0 = pops;
        drive_head();
        while (exq.size() > 0) begin
            step();
            chk(tag, {xgmii_txc, xgmii_txd}, exq.pop_front());
        end
        n = 0;
        while (tx_busy && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_busy"}, 72'(tx_busy), 72'd0);
        chk({tag, "_pops"}, 72'(pops - p0), 72'(nwords));
        chk({tag, "_drained"}, 72'(fq.size()), 72'd0);
    endtask

    initial begin
        int nw;
        int n;
        pa_hold = 1'b0;
        rst     = 1'b1;
        drive_head();
        step();
        step();
        chk("rst_out", {xgmii_txc, xgmii_txd}, IDLE_X);
        chk("rst_busy", 72'(tx_busy), 72'd0);
        chk("rst_cnt", 72'(underrun_cnt), 72'd0);
        chk("rst_rd", 72'(fifo_rd), 72'd0);
        rst = 1'b0;
        step();

        add_pkt(2, 3'd0, 64'h1111_2222_3333_4440, 1'b1);
        run_stream("pkt16", 2);
        add_pkt(2, 3'd5, 64'hA0A1_A2A3_A4A5_A6A0, 1'b1);
        run_stream("pkt13", 2);
        add_pkt(2, 3'd0, 64'h0123_4567_89AB_CDE0, 1'b1);
        add_pkt(1, 3'd3, 64'hFEDC_BA98_7654_3210, 1'b1);
        run_stream("b2b", 3);

        for (int t = 0; t < 8; t++) begin
            nw = 0;
            for (int p = 0; p < int'($urandom_range(1, 3)); p++) begin
                n = int'($urandom_range(1, 4));
                add_pkt(n, 3'($urandom_range(0, 7)), '0, 1'b0);
                nw += n;
            end
            run_stream("rand", nw);
        end

`ifndef TX_FRAMER_CUT_THROUGH_EN
        pa_hold = 1'b1;
        add_pkt(2, 3'd0, 64'h5A5A_0000_0000_0000, 1'b1);
        drive_head();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_out", {xgmii_txc, xgmii_txd}, IDLE_X);
            chk("hold_busy", 72'(tx_busy), 72'd0);
        end
        chk("hold_pops", 72'(fq.size()), 72'd2);
        pa_hold = 1'b0;
        run_stream("hold_go", 2);
`else
        fq.push_back('{d: 64'hAAAA_0000_0000_0001, eop: 1'b0, bcnt: 3'd0});
        drive_head();
        step();
        step();
        step();
        chk("ct_a", {xgmii_txc, xgmii_txd}, {8'h00, 64'hAAAA_0000_0000_0001});
        step();
        chk("ct_err", {xgmii_txc, xgmii_txd}, ERR_X);
        chk("ct_cnt", 72'(underrun_cnt), 72'd1);
        fq.push_back('{d: 64'hBBBB, eop: 1'b0, bcnt: 3'd0});
        fq.push_back('{d: 64'hCCCC, eop: 1'b1, bcnt: 3'd3});
        drive_head();
        n = 0;
        do begin
            step();
            chk("ct_drop_idle", {xgmii_txc, xgmii_txd}, IDLE_X);
            n++;
        end while (tx_busy && n < 20);
        chk("ct_drop_busy", 72'(tx_busy), 72'd0);
        chk("ct_drained", 72'(fq.size()), 72'd0);
        chk("ct_cnt_hold", 72'(underrun_cnt), 72'd1);
`endif

        fq.push_back('{d: 64'h1, eop: 1'b0, bcnt: 3'd0});
        fq.push_back('{d: 64'h2, eop: 1'b0, bcnt: 3'd0});
        fq.push_back('{d: 64'h3, eop: 1'b1, bcnt: 3'd0});
        drive_head();
        step();
        step();
        step();
        chk("mid_a", {xgmii_txc, xgmii_txd}, {8'h00, 64'h1});
        rst = 1'b1;
        #1;
        chk("mid_rd", 72'(fifo_rd), 72'd0);
        step();
        chk("mid_out", {xgmii_txc, xgmii_txd}, IDLE_X);
        chk("mid_busy", 72'(tx_busy), 72'd0);
        chk("mid_cnt", 72'(underrun_cnt), 72'd0);
        fq.delete();
        drive_head();
        rst = 1'b0;
        step();
        chk("post_out", {xgmii_txc, xgmii_txd}, IDLE_X);
        chk("post_busy", 72'(tx_busy), 72'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_xgmii_framer.md
Name: tx_xgmii_framer

Overview:
- Downstream stage of the LMAC TX packet data FIFO.
- Pops 64-bit packet words from the FIFO read side and frames them onto XGMII as start/preamble/SFD, data, terminate and IFG idles.
- Feeds `xgmii_txd`/`xgmii_txc` of the core.
- Lane 0 (bits [7:0]) is transmitted first.

Parameters:
- `IFG_WORDS`, 1, number of full idle words forced after each terminate, before the framer may return to IDLE (range 0-7).
- `CNT_W`, 16, width of the underrun counter.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  synchronous active-high reset
- `fifo_dout`  in  64  show-ahead FIFO head word; valid while `fifo_empty`=0
- `fifo_eop`  in  1  head word is the last word of its packet
- `fifo_bcnt`  in  3  valid bytes in the EOP word; 0 means 8, 1-7 literal
- `fifo_empty`  in  1  FIFO empty
- `pkt_avail`  in  1  at least one complete packet is resident in the FIFO
- `fifo_rd`  out  1  pop the head word; combinational
- `xgmii_txd`  out  64  XGMII transmit data; registered
- `xgmii_txc`  out  8  XGMII transmit control, one bit per lane; registered
- `tx_busy`  out  1  high in any state other than IDLE
- `underrun_cnt`  out  CNT_W  saturating count of underrun aborts

Behaviour:
- One clock domain. `rst` is synchronous and active-high.
- Reset values:
  - FSM=IDLE.
  - `xgmii_txd`=64'h0707070707070707, `xgmii_txc`=8'hFF.
  - `fifo_rd`=0, `tx_busy`=0, `underrun_cnt`=0.
- Timing: the XGMII word for the state/pop at cycle t appears at t+1. Combinational pop-to-output latency is 1 cycle.
- Character codes: Idle=07, Start=FB, Terminate=FD, Error=FE. `txc` bit=1 on every control lane.
- IDLE:
  - Emits an idle word.
  - Goes to PRE when the start condition holds (see Optional Feature).
- PRE:
  - Emits txd=64'hD5555555555555FB, txc=8'h01. No pop.
  - Goes to DATA.
- DATA with `fifo_empty`=0:
  - `fifo_rd`=1 and the word is emitted unchanged.
  - Non-EOP word: txc=00, stay in DATA.
  - EOP with bcnt=0: full data word, txc=00, go to TERM.
  - EOP with bcnt=n (1-7): lanes 0..n-1 carry data, lane n=FD, lanes n+1..7=07, txc=~((1<<n)-1) & 8'hFF. Go to IFG.
- DATA with `fifo_empty`=1: underrun (see Optional Feature).
- TERM: emits FD in lane 0 and 07 in lanes 1-7, txc=FF. Goes to IFG.
- IFG:
  - Emits `IFG_WORDS` idle words, counted by a 3-bit down-counter, then goes to IDLE.
  - If `IFG_WORDS`=0, goes to IDLE immediately.
  - Minimum gap from terminate word to next start word is `IFG_WORDS`+1 idle words.
- DROP (macro builds only):
  - Emits idle words.
  - `fifo_rd`=1 whenever `fifo_empty`=0; goes to IFG once an EOP word has been popped.
  - Waits in DROP while the FIFO is empty.
- `fifo_rd` is asserted only in DATA or DROP with `fifo_empty`=0; it is never asserted while empty.
- Reset mid-packet: the next word is idle (txc=FF) and the FSM returns to IDLE. FIFO contents are not flushed; the upstream FIFO reset owns that.
- `underrun_cnt` saturates at all-ones and never wraps.

Optional Feature:
- Macro: `TX_FRAMER_CUT_THROUGH_EN`.
- Defined (cut-through):
  - Start condition = `fifo_empty`=0; `pkt_avail` is ignored.
  - Underrun in DATA emits an error word: txd=all FE, txc=FF.
  - `underrun_cnt` increments and the FSM goes to DROP.
- Undefined (store-and-forward):
  - Start condition = `fifo_empty`=0 AND `pkt_avail`=1.
  - Underrun is treated as a defensive case only: emit the error word and go to IFG, with no DROP state.
  - `underrun_cnt` is tied to 0.

Test Plan:
- 16-byte packet (words A, B; B has eop=1, bcnt=0) → idle, preamble word, A/txc 00, B/txc 00, FD+07s/txc FF, then 1 idle word and IDLE; `fifo_rd` high for exactly 2 cycles.
- 13-byte packet (words A, B; B has eop=1, bcnt=5) → B bytes 0-4 data, lane5=FD, lanes 6-7=07, txc=8'hE0; no TERM word.
- Two back-to-back packets resident, `IFG_WORDS`=1 → exactly 2 idle words between the terminate-bearing word and the second FB word.
- Cut-through build: 3-word packet with the FIFO empty after word 1 → error word (all FE, txc FF), `underrun_cnt`=1; remaining words are popped silently with idles output until EOP, then IFG.
- `rst` asserted in DATA after 1 word → next output idle/txc FF, `fifo_rd`=0, `tx_busy`=0, `underrun_cnt`=0.
- Store-and-forward build: `fifo_empty`=0 with `pkt_avail`=0 → stays in IDLE with no pop until `pkt_avail`=1, then a preamble word appears 1 cycle later.
